ucore_axi_mem_slave: RTL and testbench
======================================

Name: ucore_axi_mem_slave

Overview:
Synthesizable AXI4 memory responder that sits at the slave end of the ucore_main master port. It replaces the behavioural read handler with a RAM-backed model for simulation and FPGA bring-up. Read and write channels run independently, each with one outstanding transaction. FIXED and INCR bursts are supported, up to 256 beats.

Parameters:
ADDR_W, 28, byte-address width.
DATA_W, 128, data bus width (bytes per beat NB = DATA_W/8 = 16).
ID_W, 4, transaction ID width.
MEM_WORDS, 1024, backing-store depth in DATA_W-bit words.

Ports:
clk  in  1  clock; all logic on the rising edge.
aresetn  in  1  asynchronous active-low reset.
s_axi_araddr  in  ADDR_W  read start address.
s_axi_arburst  in  2  read burst type.
s_axi_arid  in  ID_W  read ID.
s_axi_arlen  in  8  read beats minus 1.
s_axi_arsize  in  3  read beat size (ignored; full-width beats assumed).
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
s_axi_rdata  out  DATA_W  read data.
s_axi_rid  out  ID_W  read ID echo.
s_axi_rresp  out  2  read response.
s_axi_rlast  out  1  final read beat.
s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
s_axi_awaddr, s_axi_awburst, s_axi_awid, s_axi_awlen, s_axi_awsize  in  as AR  write address channel.
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
s_axi_wdata  in  DATA_W  write data.
s_axi_wstrb  in  NB  byte strobes.
s_axi_wlast  in  1  final write beat.
s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
s_axi_bid  out  ID_W  write ID echo.
s_axi_bresp  out  2  write response.
s_axi_bvalid / s_axi_bready  out / in  1  B handshake.

Behaviour:
- Reset: all outputs are 0; memory contents are not reset. arready and awready rise on the first clk edge after aresetn deasserts. Reset asserted mid-burst aborts the burst immediately: FSMs return to IDLE and valids go to 0.
- Word index is addr >> log2(NB); the low address bits are ignored. The index counter is ADDR_W-log2(NB) bits and wraps modulo its width.
- A beat is out of range if its index >= MEM_WORDS. Out-of-range reads return rdata = 0 and resp = DECERR (2'b11). Out-of-range writes are dropped.
- Burst type: FIXED (00) holds the index. INCR (01) adds 1 per beat. WRAP (10) and reserved (11) are treated as INCR.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready = 1. On arvalid & arready, latch id, index, len and burst; drop arready.
  - Beat 0 is presented registered on the next edge: rvalid = 1, rdata = mem[idx], rid = latched ID, rlast = (beat == len). AR-to-first-rvalid latency is 1 cycle.
  - rdata, rresp and rlast hold stable while rvalid & !rready.
  - On rvalid & rready: if not last, load the next beat on that same edge (one beat per cycle under continuous rready). If last, drop rvalid, return to R_IDLE, and raise arready on that same edge.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready = 1. On AW handshake, latch fields and a beat counter; enter W_DATA with wready = 1.
  - W_DATA: each W handshake writes byte lanes where wstrb = 1 into mem[idx], then advances idx.
  - The burst ends on the beat where count == awlen OR wlast = 1, whichever comes first. Then: wready = 0, bvalid = 1, bid = latched ID.
  - bresp priority: DECERR if any beat was out of range; else SLVERR (2'b10) if wlast disagreed with count == awlen on any beat; else OKAY.
  - W_RESP: hold B outputs until bready; then return to W_IDLE and set awready = 1.
  - W data is never accepted before the AW handshake.
- Read/write collision: a read beat loaded on the same edge as a write to the same word returns the old data. A read beat loaded on any later edge sees the new data.

Test Plan:
1. Reset release: arready = awready = 1 one edge after aresetn rises; every other output is 0.
2. Write 0x20, len 0, data 0x0123...CDEF, wstrb 0xFFFF, wlast = 1 -> bvalid with bresp 00, bid = awid. Then read 0x20 len 0 -> rvalid 1 cycle after AR, rdata matches, rlast = 1, rresp 00.
3. INCR write at 0x100, len 3, then INCR read of the same 4 beats with rready toggling 1/0 -> 4 beats in order, data held stable during stalls, rlast only on beat 3, arready back after beat 3.
4. wstrb 0x000F over a word preloaded with all 0xAA -> readback low 4 bytes are new, other 12 bytes stay 0xAA.
5. Read at index MEM_WORDS, len 1 -> 2 beats, rdata = 0, rresp 11. Write len 1 with wlast on beat 0 -> bresp 10, burst ends after 1 beat.
6. AR and AW issued in the same cycle to the same address, with aresetn pulsed mid-burst on a repeat run -> read returns old data; after the pulse, valids are 0 and new transactions complete normally.

Source files
------------

// File: rtl/ucore_axi_mem_slave.sv
// ucore_axi_mem_slave: RAM-backed AXI4 slave, independent read/write channels with one outstanding burst each
module ucore_axi_mem_slave #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [1:0]          s_axi_arburst,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [1:0]          s_axi_awburst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = ADDR_W - LB;
  localparam int MW = $clog2(MEM_WORDS);
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  function automatic logic oor(input logic [IW-1:0] i);
    return i >= IW'(MEM_WORDS);
  endfunction
  function automatic logic [IW-1:0] step(input logic [IW-1:0] i, input logic [1:0] b);
    return b == 2'b00 ? i : i + 1'b1;
  endfunction
  logic [DATA_W-1:0] mem [MEM_WORDS];
  r_state_t          r_state;
  w_state_t          w_state;
  logic [IW-1:0]     ar_idx, aw_idx, r_idx, w_idx, rd_a;
  logic [7:0]        r_len, r_cnt, w_len, w_cnt;
  logic [1:0]        r_burst, w_burst, rd_resp;
  logic [DATA_W-1:0] rd_word;
  logic              w_dec, w_slv, w_hs, w_oor, w_cnt_last, w_mis;
  logic              unused;
  assign unused     = ^{s_axi_arsize, s_axi_awsize, s_axi_araddr[LB-1:0], s_axi_awaddr[LB-1:0]};
  assign ar_idx     = s_axi_araddr[ADDR_W-1:LB];
  assign aw_idx     = s_axi_awaddr[ADDR_W-1:LB];
  // r_idx always holds the index of the next beat to load, so one read port serves both states
  assign rd_a       = r_state == R_IDLE ? ar_idx : r_idx;
  assign rd_word    = oor(rd_a) ? '0 : mem[rd_a[MW-1:0]];
  assign rd_resp    = oor(rd_a) ? 2'b11 : 2'b00;
  assign w_hs       = w_state == W_DATA && s_axi_wvalid && s_axi_wready;
  assign w_oor      = oor(w_idx);
  assign w_cnt_last = w_cnt == w_len;
  assign w_mis      = s_axi_wlast != w_cnt_last;
  always_ff @(posedge clk)
    if (w_hs && !w_oor)
      for (int b = 0; b < NB; b++)
        if (s_axi_wstrb[b]) mem[w_idx[MW-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= 2'b00;
      s_axi_rlast   <= 1'b0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_burst       <= 2'b00;
    end else if (r_state == R_IDLE) begin
      s_axi_arready <= 1'b1;
      if (s_axi_arready && s_axi_arvalid) begin
        r_state       <= R_DATA;
        s_axi_arready <= 1'b0;
        s_axi_rvalid  <= 1'b1;
        s_axi_rdata   <= rd_word;
        s_axi_rresp   <= rd_resp;
        s_axi_rid     <= s_axi_arid;
        s_axi_rlast   <= s_axi_arlen == 8'd0;
        r_len         <= s_axi_arlen;
        r_cnt         <= 8'd0;
        r_burst       <= s_axi_arburst;
        r_idx         <= step(ar_idx, s_axi_arburst);
      end
    end else if (s_axi_rready) begin
      if (s_axi_rlast) begin
        r_state       <= R_IDLE;
        s_axi_arready <= 1'b1;
        s_axi_rvalid  <= 1'b0;
        s_axi_rlast   <= 1'b0;
      end else begin
        s_axi_rdata   <= rd_word;
        s_axi_rresp   <= rd_resp;
        s_axi_rlast   <= r_cnt + 8'd1 == r_len;
        r_cnt         <= r_cnt + 8'd1;
        r_idx         <= step(r_idx, r_burst);
      end
    end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= 2'b00;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_burst       <= 2'b00;
      w_dec         <= 1'b0;
      w_slv         <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awready && s_axi_awvalid) begin
            w_state       <= W_DATA;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            s_axi_bid     <= s_axi_awid;
            w_idx         <= aw_idx;
            w_len         <= s_axi_awlen;
            w_cnt         <= 8'd0;
            w_burst       <= s_axi_awburst;
            w_dec         <= 1'b0;
            w_slv         <= 1'b0;
          end
        end
        W_DATA:
          if (w_hs) begin
            w_idx <= step(w_idx, w_burst);
            w_cnt <= w_cnt + 8'd1;
            w_dec <= w_dec | w_oor;
            w_slv <= w_slv | w_mis;
            // an early wlast or a missing wlast both close the burst
            if (w_cnt_last || s_axi_wlast) begin
              w_state      <= W_RESP;
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_dec | w_oor) ? 2'b11 : (w_slv | w_mis) ? 2'b10 : 2'b00;
            end
          end
        W_RESP:
          if (s_axi_bready) begin
            w_state       <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
          end
        default: w_state <= W_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ucore_axi_mem_slave.sv
// tb_ucore_axi_mem_slave: directed plus randomized bursts checked against a word-array model of the memory
module tb_ucore_axi_mem_slave;
  logic clk = 1'b0, aresetn = 1'b0;
  logic [27:0] araddr = '0, awaddr = '0;
  logic [1:0] arburst = '0, awburst = '0, rresp, bresp;
  logic [3:0] arid = '0, awid = '0, rid, bid;
  logic [7:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = 3'd4, awsize = 3'd4;
  logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic [127:0] rdata, wdata = '0;
  logic [15:0] wstrb = '0;
  logic [127:0] mdl [1024];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  ucore_axi_mem_slave dut (
    .clk(clk), .aresetn(aresetn),
    .s_axi_araddr(araddr), .s_axi_arburst(arburst), .s_axi_arid(arid), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awburst(awburst), .s_axi_awid(awid), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [127:0] mexp(input logic [23:0] i);
    return i >= 24'd1024 ? 128'd0 : mdl[i[9:0]];
  endfunction
  task automatic wr(input logic [27:0] a, input logic [7:0] len, input logic [1:0] bst, input logic [3:0] id,
                    input logic [15:0] strb, input int wlb, input logic [127:0] d0, input bit rnd);
    logic [23:0] idx;
    logic [127:0] d;
    logic hs, dec;
    int nb;
    idx = a[27:4];
    dec = 1'b0;
    nb = (wlb < int'(len) ? wlb : int'(len)) + 1;
    awaddr = a; awlen = len; awburst = bst; awid = id; awvalid = 1'b1; hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin hs = awready; @(posedge clk); #1; end
    awvalid = 1'b0;
    chk("aw_handshake", hs, 1);
    for (int k = 0; k < nb; k++) begin
      if (rnd && $urandom_range(3) == 0) begin @(posedge clk); #1; end
      d = rnd ? {$urandom, $urandom, $urandom, $urandom} : d0 + 128'(k);
      wdata = d; wstrb = strb; wlast = k == wlb; wvalid = 1'b1; hs = 1'b0;
      for (int t = 0; t < 50 && !hs; t++) begin hs = wready; @(posedge clk); #1; end
      wvalid = 1'b0; wlast = 1'b0;
      chk("w_handshake", hs, 1);
      if (idx >= 24'd1024) dec = 1'b1;
      else for (int b = 0; b < 16; b++) if (strb[b]) mdl[idx[9:0]][b*8 +: 8] = d[b*8 +: 8];
      idx = bst == 2'b00 ? idx : idx + 24'd1;
    end
    chk("wready_after_last", wready, 0);
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, dec ? 2'b11 : (wlb != int'(len)) ? 2'b10 : 2'b00);
    if (rnd) repeat ($urandom_range(2)) begin @(posedge clk); #1; chk("bvalid_hold", bvalid, 1); end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask
  // stall: 0 = continuous rready, 1 = random stalls, 2 = stall once before every beat
  task automatic rd(input logic [27:0] a, input logic [7:0] len, input logic [1:0] bst, input logic [3:0] id,
                    input int stall);
    logic [23:0] idx;
    logic [127:0] ed;
    logic hs;
    idx = a[27:4];
    ed = '0;
    araddr = a; arlen = len; arburst = bst; arid = id; arvalid = 1'b1; hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin ed = mexp(idx); hs = arready; @(posedge clk); #1; end
    arvalid = 1'b0;
    chk("ar_handshake", hs, 1);
    for (int k = 0; k <= int'(len); k++) begin
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, ed);
      chk("rresp", rresp, idx >= 24'd1024 ? 2'b11 : 2'b00);
      chk("rlast", rlast, k == int'(len));
      chk("rid", rid, id);
      if (stall == 2 || (stall == 1 && $urandom_range(1) == 1)) begin
        rready = 1'b0; @(posedge clk); #1;
        chk("rvalid_stall", rvalid, 1);
        chk("rdata_stall", rdata, ed);
        chk("rlast_stall", rlast, k == int'(len));
      end
      idx = bst == 2'b00 ? idx : idx + 24'd1;
      ed = mexp(idx);
      rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    end
    chk("rvalid_end", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask
  initial begin
    logic [127:0] old, nd;
    int w0, ln, wlb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    aresetn = 1'b1; #1;
    chk("rel_arready_pre_edge", arready, 0);
    @(posedge clk); #1;
    chk("rel_arready", arready, 1);
    chk("rel_awready", awready, 1);
    wr(28'h0, 8'd63, 2'b01, 4'h0, 16'hFFFF, 63, '0, 1'b1);
    wr(28'h20, 8'd0, 2'b01, 4'h5, 16'hFFFF, 0, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    rd(28'h20, 8'd0, 2'b01, 4'h6, 0);
    wr(28'h100, 8'd3, 2'b01, 4'hA, 16'hFFFF, 3, '0, 1'b1);
    rd(28'h100, 8'd3, 2'b01, 4'hB, 2);
    wr(28'h300, 8'd0, 2'b01, 4'h1, 16'hFFFF, 0, {16{8'hAA}}, 1'b0);
    wr(28'h300, 8'd0, 2'b01, 4'h1, 16'h000F, 0, 128'h11223344556677889900AABBCCDDEEFF, 1'b0);
    rd(28'h300, 8'd0, 2'b01, 4'h2, 0);
    rd(28'h4000, 8'd1, 2'b01, 4'h7, 1);
    wr(28'h40, 8'd1, 2'b01, 4'h2, 16'hFFFF, 0, '0, 1'b1);
    rd(28'h40, 8'd1, 2'b01, 4'h3, 0);
    wr(28'h3FE0, 8'd3, 2'b01, 4'h4, 16'hFFFF, 3, '0, 1'b1);
    rd(28'h3FE0, 8'd3, 2'b01, 4'h4, 1);
    wr(28'h50, 8'd3, 2'b00, 4'h8, 16'hFFFF, 3, '0, 1'b1);
    rd(28'h50, 8'd3, 2'b00, 4'h9, 1);
    wr(28'h60, 8'd2, 2'b11, 4'hC, 16'hFFFF, 2, '0, 1'b1);
    rd(28'h60, 8'd2, 2'b10, 4'hD, 0);
    rd(28'h30, 8'd255, 2'b00, 4'hE, 0);
    for (int i = 0; i < 25; i++) begin
      w0 = $urandom_range(55);
      ln = $urandom_range(7);
      wlb = $urandom_range(3) == 0 ? $urandom_range(8) : ln;
      wr(28'(w0 << 4), 8'(ln), 2'($urandom), 4'($urandom), 16'($urandom), wlb, '0, 1'b1);
      rd(28'(w0 << 4), 8'(ln), 2'($urandom), 4'($urandom), 1);
    end
    // read beat loaded on the same edge as the write to that word
    old = mdl[5];
    nd = {$urandom, $urandom, $urandom, $urandom};
    awaddr = 28'h50; awlen = 8'd0; awburst = 2'b01; awid = 4'h3; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    chk("col_wready", wready, 1);
    wdata = nd; wstrb = 16'hFFFF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 28'h50; arlen = 8'd0; arburst = 2'b01; arid = 4'h9; arvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    mdl[5] = nd;
    chk("col_rvalid", rvalid, 1);
    chk("col_rdata_old", rdata, old);
    chk("col_bvalid", bvalid, 1);
    chk("col_bresp", bresp, 2'b00);
    rready = 1'b1; bready = 1'b1; @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
    rd(28'h50, 8'd0, 2'b01, 4'h2, 0);
    awaddr = 28'h80; awlen = 8'd7; awburst = 2'b01; awid = 4'h6; awvalid = 1'b1;
    araddr = 28'h80; arlen = 8'd7; arburst = 2'b01; arid = 4'h6; arvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_wready", wready, 1);
    #2 aresetn = 1'b0; #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_rlast", rlast, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_wready", wready, 0);
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_arready", arready, 0);
    chk("midrst_awready", awready, 0);
    @(posedge clk); #1; aresetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_arready", arready, 1);
    chk("post_rst_awready", awready, 1);
    wr(28'h80, 8'd1, 2'b01, 4'h5, 16'hFFFF, 1, '0, 1'b1);
    rd(28'h80, 8'd3, 2'b01, 4'h5, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
